// File: rtl/axi_stream_dw_downsizer.sv
`default_nettype none
// ============================================================================
// axi_stream_dw_downsizer: splits one wide AXI-Stream beat into narrow lanes, LS lane first.
// Rev 1.0 -- optional assertions under AXI_STREAM_DW_DOWNSIZER_ASSERT_EN
// ============================================================================
module axi_stream_dw_downsizer #(
  parameter int DataWidthIn  = 32,
  parameter int DataWidthOut = 8,
  parameter int IdWidth      = 0,
  parameter int DestWidth    = 0,
  parameter int UserWidth    = 0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         in_tvalid_i,
  output logic                                         in_tready_o,
  input  logic [DataWidthIn-1:0]                       in_tdata_i,
  input  logic [DataWidthIn/8-1:0]                     in_tstrb_i,
  input  logic [DataWidthIn/8-1:0]                     in_tkeep_i,
  input  logic                                         in_tlast_i,
  input  logic [((IdWidth   > 0) ? IdWidth   : 1)-1:0] in_tid_i,
  input  logic [((DestWidth > 0) ? DestWidth : 1)-1:0] in_tdest_i,
  input  logic [((UserWidth > 0) ? UserWidth : 1)-1:0] in_tuser_i,
  output logic                                         out_tvalid_o,
  input  logic                                         out_tready_i,
  output logic [DataWidthOut-1:0]                      out_tdata_o,
  output logic [DataWidthOut/8-1:0]                    out_tstrb_o,
  output logic [DataWidthOut/8-1:0]                    out_tkeep_o,
  output logic                                         out_tlast_o,
  output logic [((IdWidth   > 0) ? IdWidth   : 1)-1:0] out_tid_o,
  output logic [((DestWidth > 0) ? DestWidth : 1)-1:0] out_tdest_o,
  output logic [((UserWidth > 0) ? UserWidth : 1)-1:0] out_tuser_o
);

  localparam int RATIO  = DataWidthIn / DataWidthOut;
  localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BI     = DataWidthIn / 8;
  localparam int BO     = DataWidthOut / 8;
  localparam int ID_W   = (IdWidth   > 0) ? IdWidth   : 1;
  localparam int DEST_W = (DestWidth > 0) ? DestWidth : 1;
  localparam int USER_W = (UserWidth > 0) ? UserWidth : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic                   full_q, full_d;
  logic [IDX_W-1:0]       idx_q,  idx_d;
  logic [DataWidthIn-1:0] data_q, data_d;
  logic [BI-1:0]          strb_q, strb_d;
  logic [BI-1:0]          keep_q, keep_d;
  logic                   last_q, last_d;
  logic [ID_W-1:0]        id_q,   id_d;
  logic [DEST_W-1:0]      dest_q, dest_d;
  logic [USER_W-1:0]      user_q, user_d;

  logic w_last_lane;
  logic w_in_hs;
  logic w_out_hs;

  assign w_last_lane = (idx_q == LAST_IDX);
  // The input may refill in the same cycle the last lane leaves, so no bubble between wide beats.
  assign in_tready_o = !full_q || (w_last_lane && out_tready_i);
  assign w_in_hs     = in_tvalid_i && in_tready_o;
  assign w_out_hs    = full_q && out_tready_i;

  always_comb begin
    full_d = full_q;
    idx_d  = idx_q;
    data_d = data_q;
    strb_d = strb_q;
    keep_d = keep_q;
    last_d = last_q;
    id_d   = id_q;
    dest_d = dest_q;
    user_d = user_q;
    if (w_in_hs) begin
      full_d = 1'b1;
      idx_d  = '0;
      data_d = in_tdata_i;
      strb_d = in_tstrb_i;
      keep_d = in_tkeep_i;
      last_d = in_tlast_i;
      id_d   = (IdWidth   > 0) ? in_tid_i   : '0;
      dest_d = (DestWidth > 0) ? in_tdest_i : '0;
      user_d = (UserWidth > 0) ? in_tuser_i : '0;
    end else if (w_out_hs) begin
      if (w_last_lane) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
      strb_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      id_q   <= '0;
      dest_q <= '0;
      user_q <= '0;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      strb_q <= strb_d;
      keep_q <= keep_d;
      last_q <= last_d;
      id_q   <= id_d;
      dest_q <= dest_d;
      user_q <= user_d;
    end
  end

  logic [DataWidthOut-1:0] w_data_lanes [RATIO];
  logic [BO-1:0]           w_strb_lanes [RATIO];
  logic [BO-1:0]           w_keep_lanes [RATIO];

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    assign w_data_lanes[g] = data_q[g*DataWidthOut +: DataWidthOut];
    assign w_strb_lanes[g] = strb_q[g*BO +: BO];
    assign w_keep_lanes[g] = keep_q[g*BO +: BO];
  end

  if (RATIO == 1) begin : g_passthru
    assign out_tdata_o = w_data_lanes[0];
    assign out_tstrb_o = w_strb_lanes[0];
    assign out_tkeep_o = w_keep_lanes[0];
  end else begin : g_select
    assign out_tdata_o = w_data_lanes[idx_q];
    assign out_tstrb_o = w_strb_lanes[idx_q];
    assign out_tkeep_o = w_keep_lanes[idx_q];
  end

  assign out_tvalid_o = full_q;
  assign out_tlast_o  = last_q && w_last_lane;
  assign out_tid_o    = id_q;
  assign out_tdest_o  = dest_q;
  assign out_tuser_o  = user_q;

`ifdef AXI_STREAM_DW_DOWNSIZER_ASSERT_EN
  if (((DataWidthIn % DataWidthOut) != 0) || ((DataWidthOut % 8) != 0)) begin : g_bad_widths
    $error("axi_stream_dw_downsizer: DataWidthIn must be a multiple of DataWidthOut, which must be a multiple of 8");
  end

  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_tvalid_o && !out_tready_i) |=> (out_tvalid_o &&
      $stable({out_tdata_o, out_tstrb_o, out_tkeep_o, out_tlast_o, out_tid_o, out_tdest_o, out_tuser_o})));

  a_in_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (in_tvalid_i && !in_tready_o) |=> (in_tvalid_i &&
      $stable({in_tdata_i, in_tstrb_i, in_tkeep_i, in_tlast_i, in_tid_i, in_tdest_i, in_tuser_i})));
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_dw_downsizer.sv
`default_nettype none
// ============================================================================
// tb_axi_stream_dw_downsizer: scoreboard bench for the 32->8 downsizer.
// Rev 1.0
// ============================================================================
module tb_axi_stream_dw_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_tvalid;
  logic        in_tready;
  logic [31:0] in_tdata;
  logic [3:0]  in_tstrb;
  logic [3:0]  in_tkeep;
  logic        in_tlast;
  logic [0:0]  in_tid, in_tdest, in_tuser;
  logic        out_tvalid;
  logic        out_tready;
  logic [7:0]  out_tdata;
  logic [0:0]  out_tstrb, out_tkeep;
  logic        out_tlast;
  logic [0:0]  out_tid, out_tdest, out_tuser;

  always #5 clk = ~clk;

  axi_stream_dw_downsizer #(
    .DataWidthIn (32),
    .DataWidthOut(8),
    .IdWidth     (0),
    .DestWidth   (0),
    .UserWidth   (0)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_tvalid_i (in_tvalid),
    .in_tready_o (in_tready),
    .in_tdata_i  (in_tdata),
    .in_tstrb_i  (in_tstrb),
    .in_tkeep_i  (in_tkeep),
    .in_tlast_i  (in_tlast),
    .in_tid_i    (in_tid),
    .in_tdest_i  (in_tdest),
    .in_tuser_i  (in_tuser),
    .out_tvalid_o(out_tvalid),
    .out_tready_i(out_tready),
    .out_tdata_o (out_tdata),
    .out_tstrb_o (out_tstrb),
    .out_tkeep_o (out_tkeep),
    .out_tlast_o (out_tlast),
    .out_tid_o   (out_tid),
    .out_tdest_o (out_tdest),
    .out_tuser_o (out_tuser)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       k;
    logic       l;
  } lane_t;

  lane_t sb[$];
  int    errs   = 0;
  int    checks = 0;
  int    n_out  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sampled mid-cycle: a handshake seen here completes at the next rising edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (in_tvalid && in_tready) begin
        for (int i = 0; i < 4; i++)
          sb.push_back('{d: in_tdata[8*i +: 8], s: in_tstrb[i], k: in_tkeep[i], l: in_tlast && (i == 3)});
      end
      if (prev_stall)
        check_val("stall_hold", {out_tvalid, out_tdata, out_tlast}, {1'b1, prev_data, prev_last});
      if (out_tvalid && out_tready) begin
        n_out++;
        if (sb.size() == 0) begin
          check_val("unexpected_out", {out_tdata, out_tlast}, 9'h0);
        end else begin
          lane_t e;
          e = sb.pop_front();
          check_val("lane_data", out_tdata, e.d);
          check_val("lane_strb_keep", {out_tstrb, out_tkeep}, {e.s, e.k});
          check_val("lane_last", out_tlast, e.l);
        end
      end
      prev_stall = out_tvalid && !out_tready;
      prev_data  = out_tdata;
      prev_last  = out_tlast;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a beat and returns 1 ns after the edge that accepted it.
  task automatic send(input logic [31:0] d, input logic l, input logic [3:0] s, output int waited);
    logic hs;
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tlast  = l;
    in_tstrb  = s;
    in_tkeep  = ~s | 4'b0101;
    waited    = 0;
    hs        = 1'b0;
    while (!hs && waited < 50) begin
      @(negedge clk);
      hs = in_tready;
      waited++;
      @(posedge clk);
      #1;
    end
    if (!hs) check_val("hs_timeout", 0, 1);
  endtask

  task automatic idle();
    in_tvalid = 1'b0;
  endtask

  int w;
  int base;

  initial begin
    rst        = 1'b1;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    in_tstrb   = '0;
    in_tkeep   = '0;
    in_tlast   = 1'b0;
    in_tid     = '0;
    in_tdest   = '0;
    in_tuser   = '0;
    out_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_state", {out_tvalid, out_tlast, out_tdata, in_tready}, {1'b0, 1'b0, 8'h00, 1'b1});
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);

    // Single beat, tlast=0: four lanes then valid drops
    base = n_out;
    send(32'h1234_56EF, 1'b0, 4'hF, w);
    idle();
    check_val("lat_valid", out_tvalid, 1'b1);
    check_val("lat_lane0", out_tdata, 8'hEF);
    tick(4);
    check_val("single_count", n_out - base, 4);
    check_val("starve_drop", out_tvalid, 1'b0);
    check_val("sideband_zero", {out_tid, out_tdest, out_tuser}, 3'b000);

    // Same beat with tlast=1
    send(32'h1234_56EF, 1'b1, 4'b1010, w);
    idle();
    tick(5);

    // Back-to-back beats, no bubble
    base = n_out;
    send(32'h1234_56EF, 1'b0, 4'hF, w);
    send(32'h1234_56EF, 1'b1, 4'hF, w);
    check_val("b2b_ready_wait", w, 4);
    idle();
    check_val("b2b_lane0", {out_tvalid, out_tdata}, {1'b1, 8'hEF});
    tick(4);
    check_val("b2b_count", n_out - base, 8);
    check_val("b2b_drop", out_tvalid, 1'b0);

    // Second beat delayed 4 cycles
    send(32'h1234_56EF, 1'b0, 4'hF, w);
    idle();
    tick(4);
    check_val("gap_valid_low", out_tvalid, 1'b0);
    send(32'h1234_56EF, 1'b1, 4'hF, w);
    idle();
    check_val("gap_resume", {out_tvalid, out_tdata}, {1'b1, 8'hEF});
    tick(4);

    // Backpressure pattern 1,0,1,1,0,1
    base = n_out;
    send(32'h1234_56EF, 1'b1, 4'hF, w);
    idle();
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int i = 0; i < 6; i++) begin
        out_tready = pat[i];
        tick(1);
      end
    end
    out_tready = 1'b1;
    check_val("bp_count", n_out - base, 4);
    check_val("bp_drop", out_tvalid, 1'b0);

    // Reset while lane 56 is pending
    send(32'h1234_56EF, 1'b0, 4'hF, w);
    idle();
    tick(1);
    out_tready = 1'b0;
    check_val("rst_pending_lane", out_tdata, 8'h56);
    #2 rst = 1'b1;
    #1;
    check_val("rst_async", {out_tvalid, in_tready, out_tdata}, {1'b0, 1'b1, 8'h00});
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_tready = 1'b1;
    send(32'hA1B2_C3D4, 1'b1, 4'b0110, w);
    idle();
    check_val("post_rst_lane0", {out_tvalid, out_tdata}, {1'b1, 8'hD4});
    tick(4);

    // Random back-to-back traffic
    for (int i = 0; i < 6; i++)
      send($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), w);
    idle();
    tick(30);
    check_val("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
